// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button conditioning stage.
// Defaults are sized for a 50 MHz system clock.
package key_debounce_pkg;

  // Per-key debounce state: idle at an accepted level, or timing a candidate level.
  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } deb_state_t;

  localparam int DEF_WIDTH           = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms at 50 MHz
  localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz

  // Counter width able to hold 0 .. n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: 2-flop synchroniser, debounce counter/FSM and registered
// press/release pulses. key_clean keeps the pin's active-low polarity.
// Optional auto-repeat of key_press while held: define KEY_DEBOUNCE_REPEAT_EN.
module key_debounce_bit
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean,
  output logic key_press,
  output logic key_release
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_d;
  logic          sync_q;
  deb_state_t    state;
  logic [CW-1:0] count;
  logic          mismatch;
  logic          accept;
  logic          repeat_fire;

  // Synchronised level differs from the accepted one.
  assign mismatch = (sync_q != key_clean);
  // Candidate level has now been seen for DEBOUNCE_CYCLES consecutive samples.
  assign accept   = (state == COUNT) && mismatch && (count == CNT_LAST);

  // Two-stage synchroniser; resets to the released level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_d <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync_d <= key_raw;
      sync_q <= sync_d;
    end
  end

  // Debounce FSM: any return to the accepted level restarts the wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= STABLE;
      count       <= '0;
      key_clean   <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= (accept && !sync_q) || repeat_fire;
      key_release <= accept && sync_q;
      case (state)
        STABLE: begin
          if (mismatch) begin
            state <= COUNT;
            count <= CW'(1);
          end else begin
            count <= '0;
          end
        end
        COUNT: begin
          if (!mismatch) begin
            state <= STABLE;
            count <= '0;
          end else if (count == CNT_LAST) begin
            key_clean <= sync_q;
            state     <= STABLE;
            count     <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= STABLE;
          count <= '0;
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_w(RMAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_periodic;
  logic [RW-1:0] rpt_last;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign rpt_last    = rpt_periodic ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  // An accept while held is a release, which must never be shadowed by a repeat.
  assign repeat_fire = !key_clean && !accept && (rpt_cnt == rpt_last);

  // Repeat timer: runs only while the accepted level is pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
    end else if (key_clean || accept) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b0;
    end else if (repeat_fire) begin
      rpt_cnt      <= '0;
      rpt_periodic <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end
`else
  assign repeat_fire = 1'b0;

  // Repeat timing has no effect in this build; the block only keeps the
  // parameters referenced.
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_unused
  end
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounced, synchronised push-button inputs for the PIO in_port, plus
// one-cycle press/release pulses for local logic. Each key is independent.
// Optional auto-repeat of key_press while held: define KEY_DEBOUNCE_REPEAT_EN.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_clean,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  // One fully independent conditioning channel per key.
  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_bit (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_raw[i]),
      .key_clean   (key_clean[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
// Reference: a key level is accepted once the last 8 synchronised samples
// (raw pin delayed by two edges) all disagree with the accepted level.
module tb_key_debounce;

  localparam int W  = 2;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] key_raw;
  logic [W-1:0] key_clean;
  logic [W-1:0] key_press;
  logic [W-1:0] key_release;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] fin[$];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_press;
  logic [W-1:0] m_release;
  int           held_t[W];
  int           press_cnt0;

  key_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_raw     (key_raw),
    .key_clean   (key_clean),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    fin.delete();
    repeat (2) raw_hist.push_back('1);
    repeat (D) fin.push_back('1);
    m_clean   = '1;
    m_press   = '0;
    m_release = '0;
    for (int i = 0; i < W; i++) held_t[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] seen;
    logic [W-1:0] old_clean;
    bit           all_diff;
    seen = raw_hist[0];
    raw_hist.push_back(key_raw);
    void'(raw_hist.pop_front());
    fin.push_back(seen);
    void'(fin.pop_front());
    old_clean = m_clean;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      foreach (fin[j]) if (fin[j][i] == old_clean[i]) all_diff = 1'b0;
      if (all_diff) m_clean[i] = ~old_clean[i];
    end
    m_press   = old_clean & ~m_clean;
    m_release = ~old_clean & m_clean;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    for (int i = 0; i < W; i++) begin
      if (m_press[i]) held_t[i] = 0;
      else if (!old_clean[i] && !m_clean[i]) begin
        held_t[i]++;
        if (held_t[i] == RD || (held_t[i] > RD && (held_t[i] - RD) % RP == 0))
          m_press[i] = 1'b1;
      end
    end
`endif
  endtask

  // One clock: advance model, then compare all outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("key_clean", key_clean, m_clean);
    chk("key_press", key_press, m_press);
    chk("key_release", key_release, m_release);
    press_cnt0 += int'(key_press[0]);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Called 1 ns after an edge: pulses reset mid-cycle and checks the
  // outputs clear before any clock edge.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_clean", key_clean, 2'b11);
    chk("rst_press", key_press, 2'b00);
    chk("rst_release", key_release, 2'b00);
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  int seg_left[W];
  logic [W-1:0] seg_val;

  initial begin
    reset   = 1'b1;
    key_raw = 2'b11;
    model_reset();
    press_cnt0 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_clean", key_clean, 2'b11);
    chk("init_press", key_press, 2'b00);
    chk("init_release", key_release, 2'b00);
    #3;
    reset = 1'b0;
    ticks(3);

    // Clean press on key 0: accepted on the 10th edge, single-cycle pulse
    key_raw = 2'b10;
    ticks(9);
    chk("press_not_early", key_clean, 2'b11);
    tick();
    chk("press_latency", key_clean, 2'b10);
    chk("press_pulse", key_press, 2'b01);
    tick();
    chk("press_one_cycle", key_press, 2'b00);

    // Reset while pressed: immediate release level, then re-accepted
    async_reset();
    ticks(9);
    chk("reheld_not_early", key_press, 2'b00);
    tick();
    chk("reheld_press", key_press, 2'b01);

    // Release
    key_raw = 2'b11;
    ticks(9);
    chk("release_not_early", key_release, 2'b00);
    tick();
    chk("release_pulse", key_release, 2'b01);
    ticks(3);

    // Bounce reject: 5 low, 2 high, 5 low
    key_raw = 2'b10; ticks(5);
    key_raw = 2'b11; ticks(2);
    key_raw = 2'b10; ticks(5);
    key_raw = 2'b11; ticks(12);
    chk("bounce_clean", key_clean, 2'b11);
    key_raw = 2'b10; ticks(10);
    chk("after_bounce_press", key_clean, 2'b10);
    key_raw = 2'b11; ticks(12);

    // Both keys together
    press_cnt0 = 0;
    key_raw = 2'b00;
    ticks(10);
    chk("both_press", key_press, 2'b11);
    ticks(20);
    key_raw = 2'b11;
    ticks(10);
    chk("both_release", key_release, 2'b11);
    ticks(3);

    // Reset mid-count on key 1
    key_raw = 2'b01;
    ticks(6);
    async_reset();
    ticks(9);
    chk("midcount_not_early", key_press, 2'b00);
    tick();
    chk("midcount_press", key_press, 2'b10);
    key_raw = 2'b11;
    ticks(12);

    // Long hold on key 0: auto-repeat only when the feature is built in
    press_cnt0 = 0;
    key_raw = 2'b10;
    ticks(50);
    checks++;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    assert (press_cnt0 === 5)
    else begin errors++; $error("FAIL hold_press_count observed=%0d expected=%0d", press_cnt0, 5); end
`else
    assert (press_cnt0 === 1)
    else begin errors++; $error("FAIL hold_press_count observed=%0d expected=%0d", press_cnt0, 1); end
`endif
    key_raw = 2'b11;
    ticks(10);
    chk("hold_release", key_release, 2'b01);
    ticks(10);

    // Randomised bouncing segments on both keys, with occasional resets
    for (int i = 0; i < W; i++) seg_left[i] = 0;
    seg_val = 2'b11;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < W; i++) begin
        if (seg_left[i] == 0) begin
          seg_val[i]  = 1'($urandom_range(0, 1));
          seg_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 40))
                                                   : int'($urandom_range(1, 10));
        end
        seg_left[i]--;
      end
      key_raw = seg_val;
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream conditioning stage for the 2-bit push-button PIO input.
- Takes raw, bouncing, asynchronous board KEY pins and synchronises them to clk. Each bit is debounced independently.
- Drives the clean level into the PIO's in_port. Also gives one-cycle press/release pulses to local hardware, e.g. the game FSM.
- Pin polarity is preserved on key_clean (active-low, 1 = released), so software sees unchanged semantics.

Parameters:
- WIDTH, 2, number of keys.
- DEBOUNCE_CYCLES, 500000, cycles a new level must hold before it is accepted (10 ms at 50 MHz); must be ≥ 2.
- REPEAT_DELAY, 25000000, held-press cycles before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- key_raw, input, WIDTH, raw board pins, active-low, asynchronous to clk.
- key_clean, output, WIDTH, debounced level, active-low; feeds PIO in_port.
- key_press, output, WIDTH, one-cycle active-high pulse on accepted 1→0.
- key_release, output, WIDTH, one-cycle active-high pulse on accepted 0→1.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is asynchronous and active-high, on port reset.
  - All flops clear immediately on reset assertion.
- Reset values:
  - key_clean = all ones (released).
  - key_press = 0, key_release = 0.
  - Synchroniser flops = all ones.
  - Counters = 0; every bit FSM in STABLE.
- Synchroniser: 2-flop per bit; sync_q is the second stage. A pin change reaches sync_q after 2 rising edges.
- Per-bit FSM:
  - STABLE: counter = 0. If sync_q != key_clean, go to COUNT with counter = 1.
  - COUNT, sync_q still != key_clean:
    - If counter == DEBOUNCE_CYCLES-1: key_clean <= sync_q, pulse asserted, counter <= 0, go to STABLE.
    - Otherwise increment counter.
  - COUNT, sync_q == key_clean (bounce): counter <= 0, go to STABLE, no output change.
- Latency: a clean pin edge appears on key_clean exactly 2 + DEBOUNCE_CYCLES rising edges later.
  - A level lasting fewer than DEBOUNCE_CYCLES cycles at sync_q never propagates.
- Pulses:
  - key_press[i] is high exactly in the cycle key_clean[i] first reads 0.
  - key_release[i] is high exactly in the cycle key_clean[i] first reads 1.
  - A bit never asserts both pulses in one cycle.
  - Pulses are registered, not derived combinationally from key_raw.
- Independence: bits share no state. Simultaneous edges on several keys give simultaneous pulses.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter saturates logically and never wraps, because it is cleared on accept.
- Reset mid-count: the count is discarded and key_clean returns to 1.
  - A key held through reset release is re-accepted as a press after 2 + DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: KEY_DEBOUNCE_REPEAT_EN.
- Defined:
  - A per-bit repeat counter runs while key_clean[i] == 0.
  - key_press[i] re-pulses REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
  - The repeat counter clears on release or reset; key_release is unaffected.
- Undefined: no repeat logic is synthesised; key_press fires once per accepted press. REPEAT_* are ignored.

Decomposition:
- Package key_debounce_pkg:
  - deb_state_t enum {STABLE, COUNT}.
  - Function cnt_w(n) returning $clog2(n).
  - Default-constant localparams for 50 MHz.
- Sub-module key_debounce_bit: one key's synchroniser, counter, FSM and pulses (and optional repeat). The top instantiates WIDTH copies in a generate loop.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6):
- Reset check: assert reset mid-clock → key_clean=2'b11 and pulses=0 immediately, without waiting for a clk edge.
- Clean press: key_raw[0] 1→0 before edge 0 → key_clean[0]=0 from edge 10; key_press[0]=1 for that single cycle only; key_clean[1] stays 1.
- Bounce reject: key_raw[0] low for 5 cycles, high 2, low 5, then high → key_clean[0] stays 1 and no pulses. Then hold low 8+ cycles → accepted as in the clean press case.
- Release and both keys: both pins 1→0 at edge 0 → key_press=2'b11 at edge 10. Both 0→1 at edge 30 → key_release=2'b11 at edge 40.
- Reset mid-count: key_raw[1] low, reset pulse at edge 6 (while COUNT), pin kept low → no pulse before reset; key_press[1] at 10 edges after reset deassertion.
- Auto-repeat (REPEAT_EN defined): hold key_raw[0] low → press pulses at edges 10, 30, 36, 42. Release → pulses stop and key_release[0] fires. With the macro undefined, only the edge-10 pulse occurs.
